// File: rtl/paddle_input_ctrl_if.sv
// Paddle input bundle: raw buttons and raster position in,
// conditioned up/down levels, frame enable and vertical step out.
interface paddle_input_ctrl_if;
  logic        btnUp;
  logic        btnDown;
  logic [10:0] X;
  logic [10:0] Y;
  logic        up;
  logic        down;
  logic        enable;
  logic [4:0]  delY;

  modport master (
    output btnUp, btnDown, X, Y,
    input  up, down, enable, delY
  );

  modport slave (
    input  btnUp, btnDown, X, Y,
    output up, down, enable, delY
  );
endinterface

// File: rtl/paddle_input_ctrl.sv
// Paddle button conditioning: sync, debounce, conflict resolve, frame tick.
// Optional acceleration of delY enabled by defining PADDLE_ACCEL_EN.
module paddle_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned FRAME_LINE      = 600,
  parameter int unsigned BASE_SPEED      = 2,
  parameter int unsigned MAX_SPEED       = 8,
  parameter int unsigned ACCEL_FRAMES    = 4
) (
  input logic               clk,
  input logic               reset,
  paddle_input_ctrl_if.slave pif
);

  localparam logic [19:0] DB_LAST = 20'(DEBOUNCE_CYCLES - 1);
  localparam logic [10:0] FLINE   = 11'(FRAME_LINE);
  localparam logic [4:0]  BASE    = 5'(BASE_SPEED);
  localparam logic [4:0]  MAXS    = 5'(MAX_SPEED);
  localparam logic [3:0]  F_LAST  = 4'(ACCEL_FRAMES - 1);

  logic [1:0]  up_sync_q;
  logic [1:0]  dn_sync_q;
  logic        su_q, su_d;
  logic        sd_q, sd_d;
  logic [19:0] cu_q, cu_d;
  logic [19:0] cd_q, cd_d;
  logic        up_q;
  logic        down_q;
  logic        hit;
  logic        hit_q;
  logic        en_q;

  assign hit = (pif.X == 11'd0) && (pif.Y == FLINE);

  // Debounce next-state: a change is accepted only after a full
  // run of differing samples; any agreeing sample restarts the run.
  always_comb begin
    su_d = su_q;
    cu_d = cu_q;
    sd_d = sd_q;
    cd_d = cd_q;
    if (up_sync_q[1] == su_q) begin
      cu_d = '0;
    end else if (cu_q >= DB_LAST) begin
      su_d = up_sync_q[1];
      cu_d = '0;
    end else begin
      cu_d = cu_q + 20'd1;
    end
    if (dn_sync_q[1] == sd_q) begin
      cd_d = '0;
    end else if (cd_q >= DB_LAST) begin
      sd_d = dn_sync_q[1];
      cd_d = '0;
    end else begin
      cd_d = cd_q + 20'd1;
    end
  end

  // Synchronisers, debounce state, conflict resolution and frame tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      up_sync_q <= '0;
      dn_sync_q <= '0;
      su_q      <= 1'b0;
      sd_q      <= 1'b0;
      cu_q      <= '0;
      cd_q      <= '0;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
      hit_q     <= 1'b0;
      en_q      <= 1'b0;
    end else begin
      up_sync_q <= {up_sync_q[0], pif.btnUp};
      dn_sync_q <= {dn_sync_q[0], pif.btnDown};
      su_q      <= su_d;
      sd_q      <= sd_d;
      cu_q      <= cu_d;
      cd_q      <= cd_d;
      up_q      <= su_q & ~sd_q;
      down_q    <= sd_q & ~su_q;
      hit_q     <= hit;
      en_q      <= hit & ~hit_q;
    end
  end

  assign pif.up     = up_q;
  assign pif.down   = down_q;
  assign pif.enable = en_q;

`ifdef PADDLE_ACCEL_EN
  logic       moving;
  logic [3:0] f_q, f_d;
  logic [4:0] dly_q, dly_d;

  assign moving = up_q ^ down_q;

  // Speed next-state: every ACCEL_FRAMES moving ticks add one step,
  // any idle or conflicting tick drops back to the base speed.
  always_comb begin
    f_d   = f_q;
    dly_d = dly_q;
    if (en_q) begin
      if (moving) begin
        if (f_q >= F_LAST) begin
          f_d   = '0;
          dly_d = (dly_q >= MAXS) ? MAXS : dly_q + 5'd1;
        end else begin
          f_d = f_q + 4'd1;
        end
      end else begin
        f_d   = '0;
        dly_d = BASE;
      end
    end
  end

  // Acceleration state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_q   <= '0;
      dly_q <= BASE;
    end else begin
      f_q   <= f_d;
      dly_q <= dly_d;
    end
  end

  assign pif.delY = dly_q;
`else
  logic unused_cfg;

  assign unused_cfg = ^{F_LAST, MAXS};
  assign pif.delY   = BASE;
`endif

endmodule

// File: tb/tb_paddle_input_ctrl.sv
// Scoreboard bench for paddle_input_ctrl with a queue-based reference
// model; random buttons/resets plus directed debounce/conflict/accel cases.
module tb_paddle_input_ctrl;
  localparam int D    = 8;
  localparam int FL   = 6;
  localparam int BASE = 2;
  localparam int MAXS = 8;
  localparam int AF   = 4;
  localparam int XN   = 12;
  localparam int YN   = 10;

  logic clk = 1'b0;
  logic reset;
  paddle_input_ctrl_if pif();

  paddle_input_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .FRAME_LINE(FL),
    .BASE_SPEED(BASE),
    .MAX_SPEED(MAXS),
    .ACCEL_FRAMES(AF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pif(pif)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  logic [7:0] expq[$];
  logic up_seen = 1'b0;

  bit qu[$], qd[$];
  bit hu[$], hd[$];
  bit su, sd, ue, de, ee, hp;
  int run;

  function automatic bit flips(bit h[$], bit s);
    if (h.size() < D) return 1'b0;
    foreach (h[i]) if (h[i] == s) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    qu = '{0, 0};
    qd = '{0, 0};
    hu.delete();
    hd.delete();
    su = 0; sd = 0; ue = 0; de = 0; ee = 0; hp = 0;
    run = 0;
  endtask

  task automatic check_vec(string name, logic [7:0] e);
    logic [7:0] a;
    a = {pif.up, pif.down, pif.enable, pif.delY};
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s t=%0t up/down/en/delY act=%b/%b/%b/%0d exp=%b/%b/%b/%0d",
               name, $time, a[7], a[6], a[5], a[4:0], e[7], e[6], e[5], e[4:0]);
    end
  endtask

  task automatic check_int(string name, int a, int e);
    nvec++;
    if (a != e) begin
      nerr++;
      $display("FAIL %s t=%0t act=%0d exp=%0d", name, $time, a, e);
    end
  endtask

  // Reference model: predicts outputs after each rising edge.
  initial begin
    bit nsu, nsd, nue, nde, nee, hit;
    int ndly;
    model_reset();
    forever begin
      @(posedge clk);
      if (reset) begin
        model_reset();
        expq.push_back({3'b000, 5'(BASE)});
      end else begin
        qu.push_back(pif.btnUp);
        qd.push_back(pif.btnDown);
        hu.push_back(qu.pop_front());
        hd.push_back(qd.pop_front());
        if (hu.size() > D) void'(hu.pop_front());
        if (hd.size() > D) void'(hd.pop_front());
        nsu = flips(hu, su) ? ~su : su;
        nsd = flips(hd, sd) ? ~sd : sd;
        nue = su & ~sd;
        nde = sd & ~su;
        hit = (pif.X == 11'd0) && (pif.Y == 11'(FL));
        nee = hit & ~hp;
        if (ee) run = (ue ^ de) ? run + 1 : 0;
`ifdef PADDLE_ACCEL_EN
        ndly = BASE + run / AF;
        if (ndly > MAXS) ndly = MAXS;
`else
        ndly = BASE;
`endif
        su = nsu; sd = nsd; ue = nue; de = nde; ee = nee; hp = hit;
        expq.push_back({ue, de, ee, 5'(ndly)});
      end
    end
  end

  // Monitor: pop the prediction for every edge and compare.
  initial begin
    logic [7:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL scoreboard_empty t=%0t", $time);
      end else begin
        e = expq.pop_front();
        check_vec("cycle", e);
      end
    end
  end

  // Raster: small frame, X==0 dwells 1..3 clk so hit can last several cycles.
  initial begin
    pif.X = '0;
    pif.Y = '0;
    forever begin
      for (int y = 0; y < YN; y++) begin
        for (int x = 0; x < XN; x++) begin
          @(negedge clk);
          pif.X = 11'(x);
          pif.Y = 11'(y);
          if (x == 0) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end
    end
  end

  task automatic run_cyc(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      up_seen |= pif.up;
      @(negedge clk);
    end
  endtask

  task automatic meas_up(string name, int e);
    int lat;
    lat = 0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      @(posedge clk);
      #1;
      if (pif.up) lat = i;
    end
    check_int(name, lat, e);
    @(negedge clk);
  endtask

  task automatic wait_ticks(string name, int n);
    int cnt;
    int cyc;
    cnt = 0;
    cyc = 0;
    while (cnt < n && cyc < 20000) begin
      @(posedge clk);
      #1;
      if (pif.enable) cnt++;
      cyc++;
    end
    check_int(name, cnt, n);
    @(negedge clk);
  endtask

  initial begin
    reset       = 1'b1;
    pif.btnUp   = 1'b0;
    pif.btnDown = 1'b0;
    repeat (3) @(negedge clk);
    check_vec("reset_state", {3'b000, 5'(BASE)});
    reset = 1'b0;
    run_cyc(10);

    // Glitch in the middle of a press must restart the debounce run.
    up_seen   = 1'b0;
    pif.btnUp = 1'b1;
    run_cyc(5);
    pif.btnUp = 1'b0;
    run_cyc(1);
    check_int("glitch_no_up", int'(up_seen), 0);
    pif.btnUp = 1'b1;
    meas_up("debounce_latency", D + 3);

    // Both held -> neither direction; release down -> up returns.
    run_cyc(5);
    pif.btnDown = 1'b1;
    run_cyc(20);
    check_int("conflict_up", int'(pif.up), 0);
    check_int("conflict_down", int'(pif.down), 0);
    pif.btnDown = 1'b0;
    meas_up("conflict_release", D + 3);

    // Async reset mid-count while btnUp held.
    run_cyc(3);
    check_int("pre_reset_up", int'(pif.up), 1);
    pif.btnDown = 1'b1;
    run_cyc(4);
    reset = 1'b1;
    #1;
    check_vec("reset_async", {3'b000, 5'(BASE)});
    pif.btnDown = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    meas_up("reset_restart", D + 3);

    // Hold down for 40 frames, then release.
    pif.btnUp = 1'b0;
    run_cyc(20);
    pif.btnDown = 1'b1;
    wait_ticks("accel_ticks", 40);
    @(negedge clk);
`ifdef PADDLE_ACCEL_EN
    check_int("accel_sat", int'(pif.delY), MAXS);
`else
    check_int("accel_sat", int'(pif.delY), BASE);
`endif
    check_int("accel_down", int'(pif.down), 1);
    pif.btnDown = 1'b0;
    wait_ticks("release_ticks", 2);
    @(negedge clk);
    check_int("release_base", int'(pif.delY), BASE);

    // Random button levels with occasional async resets.
    for (int k = 0; k < 250; k++) begin
      pif.btnUp   = 1'($urandom_range(0, 1));
      pif.btnDown = 1'($urandom_range(0, 1));
      run_cyc($urandom_range(1, 14));
      if ($urandom_range(0, 29) == 0) begin
        reset = 1'b1;
        #1;
        check_vec("rand_reset", {3'b000, 5'(BASE)});
        @(negedge clk);
        reset = 1'b0;
      end
    end

    run_cyc(5);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
